// File: rtl/way_hit_encoder.sv
// rtl/way_hit_encoder.sv - one-hot to binary way encoder with 2-entry result queue
// Tracks a sticky multi-hit flag and saturating hit/miss counters for debug.
module way_hit_encoder #(
  parameter int WAYS  = 8,
  parameter int IDX_W = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WAYS-1:0]  hit_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_way,
  output logic             out_hit,
  output logic             out_multi,
  output logic             err_multi,
  input  logic             err_clr,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t state, state_n;

  logic             wptr, rptr;
  logic [IDX_W-1:0] q_way   [2];
  logic             q_hit   [2];
  logic             q_multi [2];

  logic [IDX_W-1:0] enc_way;
  logic             enc_hit;
  logic             enc_multi;
  logic             push, pop;

  // Scanning from the top down leaves the lowest set bit as the winner.
  always_comb begin
    enc_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (hit_vec[i]) enc_way = IDX_W'(i);
    end
    enc_hit   = |hit_vec;
    enc_multi = |(hit_vec & (hit_vec - WAYS'(1)));
  end

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_way   = out_valid ? q_way[rptr]   : '0;
  assign out_hit   = out_valid ? q_hit[rptr]   : 1'b0;
  assign out_multi = out_valid ? q_multi[rptr] : 1'b0;

  always_comb begin
    state_n = state;
    case (state)
      EMPTY: if (push) state_n = ONE;
      ONE: begin
        if (push && !pop)      state_n = FULL;
        else if (pop && !push) state_n = EMPTY;
      end
      FULL:    if (pop) state_n = ONE;
      default: state_n = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        q_way[i]   <= '0;
        q_hit[i]   <= 1'b0;
        q_multi[i] <= 1'b0;
      end
    end else begin
      state <= state_n;
      if (push) begin
        q_way[wptr]   <= enc_way;
        q_hit[wptr]   <= enc_hit;
        q_multi[wptr] <= enc_multi;
        wptr          <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
    end
  end

  // Set wins over clear when a multi-hit lands in the same cycle as err_clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_multi <= 1'b0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
    end else begin
      if (push && enc_multi) err_multi <= 1'b1;
      else if (err_clr)      err_multi <= 1'b0;
      if (push && enc_hit && (hit_cnt != {CNT_W{1'b1}}))
        hit_cnt <= hit_cnt + CNT_W'(1);
      if (push && !enc_hit && (miss_cnt != {CNT_W{1'b1}}))
        miss_cnt <= miss_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_way_hit_encoder.sv
// tb/tb_way_hit_encoder.sv - self-checking bench for way_hit_encoder
module tb_way_hit_encoder;

  localparam int WAYS  = 8;
  localparam int IDX_W = 3;
  localparam int CNT_W = 4;
  localparam int CMAX  = 15;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WAYS-1:0]  hit_vec = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [IDX_W-1:0] out_way;
  logic             out_hit;
  logic             out_multi;
  logic             err_multi;
  logic             err_clr = 1'b0;
  logic [CNT_W-1:0] hit_cnt;
  logic [CNT_W-1:0] miss_cnt;

  way_hit_encoder #(.WAYS(WAYS), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .hit_vec(hit_vec), .out_valid(out_valid), .out_ready(out_ready),
    .out_way(out_way), .out_hit(out_hit), .out_multi(out_multi),
    .err_multi(err_multi), .err_clr(err_clr), .hit_cnt(hit_cnt),
    .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] vec;
    int         way;
    int         hit;
    int         multi;
  } vec_t;

  vec_t tbl [14];

  int passed = 0;
  int total  = 0;

  // Reference model: queue of {way, hit, multi} plus plain integer counters.
  typedef struct { int way; int hit; int multi; } ent_t;
  ent_t m_q[$];
  int   m_hit = 0, m_miss = 0, m_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  function automatic ent_t ref_enc(input logic [7:0] v);
    ent_t e;
    logic [7:0] low;
    int n;
    n   = $countones(v);
    low = v & (~v + 8'd1);
    e.way   = (n > 0) ? $clog2(int'(low)) : 0;
    e.hit   = (n > 0) ? 1 : 0;
    e.multi = (n > 1) ? 1 : 0;
    return e;
  endfunction

  task automatic model_check();
    chk("in_ready", 32'(in_ready), 32'(m_q.size() < 2));
    chk("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      chk("out_way", 32'(out_way), 32'(m_q[0].way));
      chk("out_hit", 32'(out_hit), 32'(m_q[0].hit));
      chk("out_multi", 32'(out_multi), 32'(m_q[0].multi));
    end else begin
      chk("out_way_idle", 32'(out_way), 32'd0);
      chk("out_hit_idle", 32'(out_hit), 32'd0);
      chk("out_multi_idle", 32'(out_multi), 32'd0);
    end
    chk("err_multi", 32'(err_multi), 32'(m_err));
    chk("hit_cnt", 32'(hit_cnt), 32'(m_hit));
    chk("miss_cnt", 32'(miss_cnt), 32'(m_miss));
  endtask

  task automatic model_step();
    bit   acc, pp;
    ent_t e;
    acc = in_valid && (m_q.size() < 2);
    pp  = out_ready && (m_q.size() > 0);
    e   = ref_enc(hit_vec);
    if (pp) void'(m_q.pop_front());
    if (acc) begin
      m_q.push_back(e);
      if (e.hit != 0) begin if (m_hit < CMAX) m_hit++; end
      else if (m_miss < CMAX) m_miss++;
    end
    if (acc && e.multi != 0) m_err = 1;
    else if (err_clr) m_err = 0;
  endtask

  task automatic model_reset();
    m_q.delete();
    m_hit = 0; m_miss = 0; m_err = 0;
  endtask

  // Check current outputs against the model, then advance one clock.
  task automatic cyc();
    model_check();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int h0;
    tbl[0]  = '{8'h01, 0, 1, 0};
    tbl[1]  = '{8'h02, 1, 1, 0};
    tbl[2]  = '{8'h04, 2, 1, 0};
    tbl[3]  = '{8'h08, 3, 1, 0};
    tbl[4]  = '{8'h10, 4, 1, 0};
    tbl[5]  = '{8'h20, 5, 1, 0};
    tbl[6]  = '{8'h40, 6, 1, 0};
    tbl[7]  = '{8'h80, 7, 1, 0};
    tbl[8]  = '{8'h00, 0, 0, 0};
    tbl[9]  = '{8'h28, 3, 1, 1};
    tbl[10] = '{8'h81, 0, 1, 1};
    tbl[11] = '{8'hC0, 6, 1, 1};
    tbl[12] = '{8'hFF, 0, 1, 1};
    tbl[13] = '{8'h0A, 1, 1, 1};

    do_reset();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_hit_cnt", 32'(hit_cnt), 32'd0);

    // One-hot sweep at full throughput, one-cycle latency.
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      in_valid = 1'b1; hit_vec = tbl[i].vec;
      cyc();
      in_valid = 1'b0;
      chk("tbl_valid", 32'(out_valid), 32'd1);
      chk("tbl_way", 32'(out_way), 32'(tbl[i].way));
      chk("tbl_hit", 32'(out_hit), 32'(tbl[i].hit));
      chk("tbl_multi", 32'(out_multi), 32'(tbl[i].multi));
      if (i == 7) begin
        chk("sweep_hit_cnt", 32'(hit_cnt), 32'd8);
        chk("sweep_miss_cnt", 32'(miss_cnt), 32'd0);
        chk("sweep_err", 32'(err_multi), 32'd0);
      end
      if (i == 8) begin
        chk("zero_miss_cnt", 32'(miss_cnt), 32'd1);
        chk("zero_err", 32'(err_multi), 32'd0);
      end
      if (i == 9) chk("multi_err_set", 32'(err_multi), 32'd1);
    end
    cyc();

    // err_clr alone clears; err_clr alongside a multi-hit keeps the flag.
    err_clr = 1'b1;
    cyc();
    chk("err_cleared", 32'(err_multi), 32'd0);
    in_valid = 1'b1; hit_vec = 8'h28;
    cyc();
    in_valid = 1'b0; err_clr = 1'b0;
    chk("err_set_wins", 32'(err_multi), 32'd1);
    cyc();

    // Backpressure: fill, stall, ignored offers, then drain in order.
    out_ready = 1'b0;
    in_valid = 1'b1; hit_vec = 8'h04; cyc();
    hit_vec = 8'h40; cyc();
    h0 = int'(hit_cnt);
    chk("bp_full_ready", 32'(in_ready), 32'd0);
    hit_vec = 8'h01; cyc(); cyc();
    chk("bp_head_hold", 32'(out_way), 32'd2);
    chk("bp_cnt_hold", 32'(hit_cnt), 32'(h0));
    out_ready = 1'b1; cyc();
    chk("bp_after_pop_ready", 32'(in_ready), 32'd1);
    chk("bp_second_way", 32'(out_way), 32'd6);
    hit_vec = 8'h10; cyc();
    chk("one_pushpop_way", 32'(out_way), 32'd4);
    chk("one_pushpop_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0; cyc(); cyc();

    // Saturation with a 4-bit counter.
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      hit_vec = 8'(1 << (i % 8));
      cyc();
    end
    in_valid = 1'b0;
    chk("sat_hit_cnt", 32'(hit_cnt), 32'd15);
    cyc();
    chk("sat_hold", 32'(hit_cnt), 32'd15);

    // Async reset while FULL takes effect before the next edge.
    out_ready = 1'b0; in_valid = 1'b1; hit_vec = 8'h28;
    cyc(); cyc();
    chk("pre_rst_full", 32'(in_ready), 32'd0);
    rst = 1'b1; #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_way", 32'(out_way), 32'd0);
    chk("arst_err", 32'(err_multi), 32'd0);
    chk("arst_hit_cnt", 32'(hit_cnt), 32'd0);
    do_reset();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      int k;
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      err_clr   = ($urandom_range(7) == 0);
      k = $urandom_range(3);
      if (k == 0)      hit_vec = 8'h00;
      else if (k == 1) hit_vec = 8'(1 << $urandom_range(7));
      else             hit_vec = 8'($urandom);
      cyc();
    end
    in_valid = 1'b0;
    cyc();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
